// File: rtl/register_writeback.sv
// Write-side front end for the 32-entry integer register file: in-order result queue,
// single write port and pending-write bitmap. Optional macro: REGISTER_WRITEBACK_BYPASS_EN.
package riscv_package;
    typedef logic [4:0]  register_address_t;
    typedef logic [31:0] word_t;
endpackage

module register_writeback
    import riscv_package::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [4:0]               load_destination,
    input  logic [31:0]              load_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_destination,
    input  logic [31:0]              alu_data,
    output logic                     write_enable,
    output logic [4:0]               destination,
    output logic [31:0]              write_data,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        register_address_t dest;
        word_t             data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   tail_p1;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   free;

    logic            load_push, alu_push, pop;
    entry_t          load_entry, alu_entry;
    logic            enq0_v, enq1_v;
    entry_t          enq0, enq1;
    logic            byp_v;
    entry_t          byp_e;
    logic [1:0]      n_push;
    logic [31:0]     pending_vec;

    // Readiness looks only at the registered count, so a same-cycle pop never frees a slot.
    assign free       = CW'(DEPTH) - count_q;
    assign load_ready = !reset && (free >= CW'(1));
    assign alu_ready  = !reset && ((free >= CW'(2)) || ((free == CW'(1)) && !load_valid));

    assign load_push  = load_valid && load_ready && (load_destination != '0);
    assign alu_push   = alu_valid && alu_ready && (alu_destination != '0);
    assign pop        = (count_q != '0);
    assign load_entry = '{dest: load_destination, data: load_data};
    assign alu_entry  = '{dest: alu_destination, data: alu_data};
    assign tail_p1    = tail_q + PW'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        enq0_v = 1'b0;
        enq1_v = 1'b0;
        enq0   = '0;
        enq1   = '0;
        byp_v  = 1'b0;
        byp_e  = '0;
`ifdef REGISTER_WRITEBACK_BYPASS_EN
        if ((count_q == '0) && load_push) begin
            byp_v = 1'b1;
            byp_e = load_entry;
            if (alu_push) begin
                enq0_v = 1'b1;
                enq0   = alu_entry;
            end
        end else if ((count_q == '0) && alu_push) begin
            byp_v = 1'b1;
            byp_e = alu_entry;
        end else
`endif
        if (load_push) begin
            enq0_v = 1'b1;
            enq0   = load_entry;
            if (alu_push) begin
                enq1_v = 1'b1;
                enq1   = alu_entry;
            end
        end else if (alu_push) begin
            enq0_v = 1'b1;
            enq0   = alu_entry;
        end
    end

    assign n_push  = {1'b0, enq0_v} + {1'b0, enq1_v};
    assign head_d  = head_q + PW'(pop);
    assign tail_d  = tail_q + PW'(n_push);
    assign count_d = count_q + CW'(n_push) - CW'(pop);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (enq0_v) mem_q[tail_q]  <= enq0;
            if (enq1_v) mem_q[tail_p1] <= enq1;
        end
    end

    // A slot is occupied when its distance from head is below count.
    always_comb begin
        pending_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(i) - head_q} < count_q)
                pending_vec[mem_q[i].dest] = 1'b1;
        end
        pending_vec[0] = 1'b0;
    end

    always_comb begin
        write_enable = 1'b0;
        destination  = '0;
        write_data   = '0;
        if (!reset) begin
            if (count_q != '0) begin
                write_enable = 1'b1;
                destination  = mem_q[head_q].dest;
                write_data   = mem_q[head_q].data;
            end else if (byp_v) begin
                write_enable = 1'b1;
                destination  = byp_e.dest;
                write_data   = byp_e.data;
            end
        end
    end

    assign pending   = reset ? '0 : pending_vec;
    assign occupancy = reset ? '0 : count_q;

endmodule

// File: tb/tb_register_writeback.sv
// Randomized self-checking bench for register_writeback: a queue-based reference model
// checked every cycle, plus directed literal checks taken from the expected behaviour.
module tb_register_writeback;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0, alu_valid = 1'b0;
    logic        load_ready, alu_ready;
    logic [4:0]  load_destination = '0, alu_destination = '0;
    logic [31:0] load_data = '0, alu_data = '0;
    logic        write_enable;
    logic [4:0]  destination;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic [$clog2(DEPTH):0] occupancy;

    int errors = 0;
    int checks = 0;

    register_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_destination(load_destination), .load_data(load_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_destination(alu_destination), .alu_data(alu_data),
        .write_enable(write_enable), .destination(destination), .write_data(write_data),
        .pending(pending), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the list of accepted, not yet retired results in acceptance order.
    res_t        mq[$];
    int          free;
    bit          e_lr, e_ar, lp, ap, byp_l, byp_a;
    logic        e_we;
    logic [4:0]  e_dst;
    logic [31:0] e_dat, e_pend;
    int          e_occ;

    always @(negedge clk) begin
        #2;
        free  = DEPTH - mq.size();
        e_lr  = !reset && free >= 1;
        e_ar  = !reset && (free >= 2 || (free == 1 && !load_valid));
        lp    = load_valid && e_lr && load_destination != 0;
        ap    = alu_valid && e_ar && alu_destination != 0;
        byp_l = 0;
        byp_a = 0;
        e_we  = 0;
        e_dst = 0;
        e_dat = 0;
        e_pend = 0;
        if (!reset) begin
            if (mq.size() > 0) begin
                e_we  = 1;
                e_dst = mq[0].dest;
                e_dat = mq[0].data;
            end
`ifdef REGISTER_WRITEBACK_BYPASS_EN
            else if (lp) begin
                byp_l = 1; e_we = 1; e_dst = load_destination; e_dat = load_data;
            end else if (ap) begin
                byp_a = 1; e_we = 1; e_dst = alu_destination; e_dat = alu_data;
            end
`endif
            foreach (mq[i]) e_pend[mq[i].dest] = 1'b1;
        end
        e_occ = reset ? 0 : mq.size();

        check("load_ready", {31'b0, load_ready}, {31'b0, e_lr});
        check("alu_ready", {31'b0, alu_ready}, {31'b0, e_ar});
        check("write_enable", {31'b0, write_enable}, {31'b0, e_we});
        check("destination", {27'b0, destination}, {27'b0, e_dst});
        check("write_data", write_data, e_dat);
        check("pending", pending, e_pend);
        check("occupancy", 32'(occupancy), 32'(e_occ));

        if (reset) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (lp && !byp_l) mq.push_back('{dest: load_destination, data: load_data});
            if (ap && !byp_a) mq.push_back('{dest: alu_destination, data: alu_data});
        end
    end

    // Drive one cycle of inputs just after the falling edge; returns after the model compare.
    task automatic drive(input bit rst, input bit lv, input logic [4:0] ld, input logic [31:0] ldat,
                         input bit av, input logic [4:0] ad, input logic [31:0] adat);
        @(negedge clk);
        reset            = rst;
        load_valid       = lv;
        load_destination = ld;
        load_data        = ldat;
        alu_valid        = av;
        alu_destination  = ad;
        alu_data         = adat;
        #3;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int mode;
        bit lv, av, rst;
        logic [4:0] ld, ad;

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rst_load_ready", {31'b0, load_ready}, 32'd0);
        check("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_write_enable", {31'b0, write_enable}, 32'd0);

        idle();
        check("idle_load_ready", {31'b0, load_ready}, 32'd1);
        check("idle_alu_ready", {31'b0, alu_ready}, 32'd1);

        // Single ALU result to register 5.
        drive(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        check("single_alu_ready", {31'b0, alu_ready}, 32'd1);
`ifdef REGISTER_WRITEBACK_BYPASS_EN
        check("single_byp_we", {31'b0, write_enable}, 32'd1);
        check("single_byp_data", write_data, 32'hDEADBEEF);
        check("single_byp_pending", pending, 32'd0);
        idle();
        check("single_after_we", {31'b0, write_enable}, 32'd0);
        check("single_after_pending", pending, 32'd0);
`else
        check("single_same_cycle_we", {31'b0, write_enable}, 32'd0);
        idle();
        check("single_we", {31'b0, write_enable}, 32'd1);
        check("single_dest", {27'b0, destination}, 32'd5);
        check("single_data", write_data, 32'hDEADBEEF);
        check("single_pending", pending, 32'h0000_0020);
        check("single_occupancy", 32'(occupancy), 32'd1);
`endif
        idle();
        check("single_retired_pending", pending, 32'd0);
        check("single_retired_we", {31'b0, write_enable}, 32'd0);

        // Load and ALU to the same register in one cycle: load is older.
        drive(0, 1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        idle();
`ifdef REGISTER_WRITEBACK_BYPASS_EN
        check("pair_second_data", write_data, 32'h22);
        check("pair_occupancy", 32'(occupancy), 32'd1);
`else
        check("pair_first_data", write_data, 32'h11);
        check("pair_first_dest", {27'b0, destination}, 32'd3);
        check("pair_occupancy", 32'(occupancy), 32'd2);
        check("pair_pending", pending, 32'h0000_0008);
        idle();
        check("pair_second_data", write_data, 32'h22);
        check("pair_second_we", {31'b0, write_enable}, 32'd1);
`endif
        idle();
        idle();

        // Destination 0 is accepted but never written.
        drive(0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        check("zero_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("zero_same_we", {31'b0, write_enable}, 32'd0);
        idle();
        check("zero_occupancy", 32'(occupancy), 32'd0);
        check("zero_we", {31'b0, write_enable}, 32'd0);
        check("zero_pending", pending, 32'd0);

        // Both sources every cycle: occupancy saturates at DEPTH-1 and ALU stalls.
        for (int i = 0; i < 4; i++)
            drive(0, 1, 5'(2 * i + 1), 32'(100 + i), 1, 5'(2 * i + 2), 32'(200 + i));
        check("fill_occupancy", 32'(occupancy), 32'd3);
        check("fill_load_ready", {31'b0, load_ready}, 32'd1);
        check("fill_alu_ready", {31'b0, alu_ready}, 32'd0);
        check("fill_we", {31'b0, write_enable}, 32'd1);

        // One-cycle reset with a loaded queue.
        drive(1, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA);
        check("midrst_we", {31'b0, write_enable}, 32'd0);
        check("midrst_occupancy", 32'(occupancy), 32'd0);
        check("midrst_pending", pending, 32'd0);
        check("midrst_load_ready", {31'b0, load_ready}, 32'd0);
        idle();
        check("postrst_load_ready", {31'b0, load_ready}, 32'd1);
        check("postrst_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("postrst_occupancy", 32'(occupancy), 32'd0);
        check("postrst_we", {31'b0, write_enable}, 32'd0);

        // Randomized traffic in phases of varying density, with occasional resets.
        mode = 0;
        for (int c = 0; c < 900; c++) begin
            if (c % 60 == 0) mode = $urandom_range(0, 3);
            case (mode)
                0:       begin lv = 1; av = 1; end
                1:       begin lv = ($urandom_range(0, 1) == 1); av = ($urandom_range(0, 1) == 1); end
                2:       begin lv = ($urandom_range(0, 4) == 0); av = ($urandom_range(0, 4) == 0); end
                default: begin lv = ($urandom_range(0, 3) != 0); av = ($urandom_range(0, 3) != 0); end
            endcase
            if (mode == 3) begin
                ld = 5'($urandom_range(0, 3));
                ad = 5'($urandom_range(0, 3));
            end else begin
                ld = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ad = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            end
            rst = ($urandom_range(0, 99) == 0);
            drive(rst, lv, ld, $urandom, av, ad, $urandom);
        end

        idle();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
